// File: rtl/fb_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_read_arbiter_if
// Purpose : One read-only AXI-style channel pair (AR + R). It is used for both
//           arbiter requester ports and for the shared downstream port.
// Signals : arvalid/arready/araddr[31:0]/arprot[2:0]  read address channel
//           rvalid/rready/rdata[DATA_WIDTH-1:0]/rresp[1:0]  read data channel
// Modports: master - issues addresses and accepts data
//           slave  - accepts addresses and returns data
// -----------------------------------------------------------------------------
interface fb_read_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output arvalid, araddr, arprot, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// fb_read_arbiter
// Purpose : Two-to-one read arbiter with a single outstanding transaction.
//           Port 0 (frame reader) has priority. Port 1 wins a contested
//           request once port 0 has been granted STARVE_LIMIT times in a row
//           while port 1 was waiting.
// Ports   : aclk    - clock, rising edge
//           areset  - asynchronous active-high reset
//           s0      - port 0 requester channel (slave side)
//           s1      - port 1 requester channel (slave side)
//           m       - shared downstream channel (master side)
//           grant   - one-hot owner of the current transaction, 0 when idle
// -----------------------------------------------------------------------------
module fb_read_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    fb_read_arbiter_if.slave     s0,
    fb_read_arbiter_if.slave     s1,
    fb_read_arbiter_if.master    m,
    output logic [1:0]           grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [1:0]            grant_r;
    logic [1:0]            grant_nxt_s;
    logic                  m_arvalid_r;
    logic                  m_arvalid_nxt_s;
    logic [31:0]           m_araddr_r;
    logic [31:0]           m_araddr_nxt_s;
    logic [2:0]            m_arprot_r;
    logic [2:0]            m_arprot_nxt_s;
    logic [CNT_W-1:0]      starve_cnt_r;
    logic [CNT_W-1:0]      starve_cnt_nxt_s;

    logic                  pick0_s;
    logic                  pick1_s;

    logic                  s0_rvalid_s;
    logic [DATA_WIDTH-1:0] s0_rdata_s;
    logic [1:0]            s0_rresp_s;
    logic                  s1_rvalid_s;
    logic [DATA_WIDTH-1:0] s1_rdata_s;
    logic [1:0]            s1_rresp_s;
    logic                  m_rready_s;

    // Winner selection; only meaningful in IDLE, and suppressed while in reset
    // so that no arready can leak out during reset.
    always_comb begin
        pick0_s = 1'b0;
        pick1_s = 1'b0;
        if ((state_r == ST_IDLE) && !areset) begin
            if (s1.arvalid && (!s0.arvalid || (starve_cnt_r == STARVE_MAX))) begin
                pick1_s = 1'b1;
            end else if (s0.arvalid) begin
                pick0_s = 1'b1;
            end else begin
                pick0_s = 1'b0;
                pick1_s = 1'b0;
            end
        end else begin
            pick0_s = 1'b0;
            pick1_s = 1'b0;
        end
    end

    // Next-state and next-register values for the transaction FSM.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        m_arvalid_nxt_s  = m_arvalid_r;
        m_araddr_nxt_s   = m_araddr_r;
        m_arprot_nxt_s   = m_arprot_r;
        starve_cnt_nxt_s = starve_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick0_s) begin
                    state_nxt_s     = ST_ADDR;
                    grant_nxt_s     = 2'b01;
                    m_arvalid_nxt_s = 1'b1;
                    m_araddr_nxt_s  = s0.araddr;
                    m_arprot_nxt_s  = s0.arprot;
                end else if (pick1_s) begin
                    state_nxt_s     = ST_ADDR;
                    grant_nxt_s     = 2'b10;
                    m_arvalid_nxt_s = 1'b1;
                    m_araddr_nxt_s  = s1.araddr;
                    m_arprot_nxt_s  = s1.arprot;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
                // Starvation counter only moves on a grant: a port-0 win over a
                // waiting port 1 counts up (saturating), any port-1 win clears it.
                if (pick1_s) begin
                    starve_cnt_nxt_s = {CNT_W{1'b0}};
                end else if (pick0_s && s1.arvalid && (starve_cnt_r != STARVE_MAX)) begin
                    starve_cnt_nxt_s = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    starve_cnt_nxt_s = starve_cnt_r;
                end
            end
            ST_ADDR: begin
                if (m.arready) begin
                    state_nxt_s     = ST_DATA;
                    m_arvalid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s     = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (m.rvalid && m_rready_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = 2'b00;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                grant_nxt_s     = 2'b00;
                m_arvalid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and address-channel registers, cleared asynchronously.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r      <= ST_IDLE;
            grant_r      <= 2'b00;
            m_arvalid_r  <= 1'b0;
            m_araddr_r   <= 32'h0000_0000;
            m_arprot_r   <= 3'b000;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            m_arvalid_r  <= m_arvalid_nxt_s;
            m_araddr_r   <= m_araddr_nxt_s;
            m_arprot_r   <= m_arprot_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // R-channel steering: only the owner sees downstream data, and only in
    // DATA. Anything arriving in IDLE/ADDR (or during reset, which forces
    // IDLE) is left unacknowledged and unforwarded.
    always_comb begin
        s0_rvalid_s = 1'b0;
        s0_rdata_s  = {DATA_WIDTH{1'b0}};
        s0_rresp_s  = 2'b00;
        s1_rvalid_s = 1'b0;
        s1_rdata_s  = {DATA_WIDTH{1'b0}};
        s1_rresp_s  = 2'b00;
        m_rready_s  = 1'b0;
        if (state_r == ST_DATA) begin
            if (grant_r[0]) begin
                s0_rvalid_s = m.rvalid;
                s0_rdata_s  = m.rdata;
                s0_rresp_s  = m.rresp;
                m_rready_s  = s0.rready;
            end else if (grant_r[1]) begin
                s1_rvalid_s = m.rvalid;
                s1_rdata_s  = m.rdata;
                s1_rresp_s  = m.rresp;
                m_rready_s  = s1.rready;
            end else begin
                m_rready_s  = 1'b0;
            end
        end else begin
            m_rready_s = 1'b0;
        end
    end

    assign s0.arready = pick0_s;
    assign s1.arready = pick1_s;
    assign s0.rvalid  = s0_rvalid_s;
    assign s0.rdata   = s0_rdata_s;
    assign s0.rresp   = s0_rresp_s;
    assign s1.rvalid  = s1_rvalid_s;
    assign s1.rdata   = s1_rdata_s;
    assign s1.rresp   = s1_rresp_s;
    assign m.arvalid  = m_arvalid_r;
    assign m.araddr   = m_araddr_r;
    assign m.arprot   = m_arprot_r;
    assign m.rready   = m_rready_s;
    assign grant      = grant_r;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_read_arbiter
// Purpose : Self-checking bench for fb_read_arbiter. Directed scenarios first,
//           then randomized transactions checked against a transaction-level
//           model (winner choice from the priority/starvation rule, expected
//           R routing from the values the bench itself drives).
// -----------------------------------------------------------------------------
module tb_fb_read_arbiter;

    localparam int DW    = 32;
    localparam int LIMIT = 8;

    logic       aclk = 1'b0;
    logic       areset;
    logic [1:0] grant;

    fb_read_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
    fb_read_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
    fb_read_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

    int n_cmp    = 0;
    int n_err    = 0;
    int starve_m = 0;   // model: consecutive port-0 wins over a waiting port 1

    fb_read_arbiter #(
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s0     (s0_if),
        .s1     (s1_if),
        .m      (m_if),
        .grant  (grant)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic [31:0] a, input logic [2:0] pr);
        if (p == 0) begin
            s0_if.arvalid = 1'b1; s0_if.araddr = a; s0_if.arprot = pr;
        end else begin
            s1_if.arvalid = 1'b1; s1_if.araddr = a; s1_if.arprot = pr;
        end
    endtask

    // Reference rule: port 0 wins contested requests unless port 1 has already
    // been passed over LIMIT times.
    function automatic int ref_winner();
        if (s0_if.arvalid && s1_if.arvalid) return (starve_m >= LIMIT) ? 1 : 0;
        else if (s1_if.arvalid) return 1;
        else return 0;
    endfunction

    // One full transaction starting in IDLE with requests already driven.
    task automatic do_txn(input int win, input int ar_dly, input int r_pre,
                          input int rr_stall, input logic [31:0] data,
                          input logic [1:0] resp, input bit late1);
        logic [31:0] ea;
        logic [2:0]  ep;
        logic [1:0]  eg;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        bt;
        logic        rr;
        ea = (win == 0) ? s0_if.araddr : s1_if.araddr;
        ep = (win == 0) ? s0_if.arprot : s1_if.arprot;
        eg = (win == 0) ? 2'b01 : 2'b10;
        // grant cycle
        @(negedge aclk);
        chk("idle_arready0", s0_if.arready, (win == 0));
        chk("idle_arready1", s1_if.arready, (win == 1));
        chk("idle_grant", grant, 2'b00);
        chk("idle_m_arvalid", m_if.arvalid, 1'b0);
        chk("idle_m_rready", m_if.rready, 1'b0);
        if (win == 1) starve_m = 0;
        else if (s1_if.arvalid && starve_m < LIMIT) starve_m++;
        @(posedge aclk); #1;
        if (win == 0) s0_if.arvalid = 1'b0; else s1_if.arvalid = 1'b0;
        // address phase, with spurious downstream beats sprinkled in
        for (int i = 0; i <= ar_dly; i++) begin
            m_if.arready = (i == ar_dly);
            m_if.rvalid  = 1'($urandom % 2);
            m_if.rdata   = $urandom;
            s0_if.rready = 1'($urandom % 2);
            s1_if.rready = 1'($urandom % 2);
            if (late1 && i == 0) req(1, 32'h0000_4000, 3'd2);
            @(negedge aclk);
            chk("addr_grant", grant, eg);
            chk("addr_m_arvalid", m_if.arvalid, 1'b1);
            chk("addr_m_araddr", m_if.araddr, ea);
            chk("addr_m_arprot", m_if.arprot, ep);
            chk("addr_arready0", s0_if.arready, 1'b0);
            chk("addr_arready1", s1_if.arready, 1'b0);
            chk("addr_m_rready", m_if.rready, 1'b0);
            chk("addr_rvalid0", s0_if.rvalid, 1'b0);
            chk("addr_rvalid1", s1_if.rvalid, 1'b0);
            @(posedge aclk); #1;
        end
        m_if.arready = 1'b0;
        // data phase: r_pre idle cycles, then a beat held rr_stall cycles
        for (int i = 0; i <= r_pre + rr_stall; i++) begin
            bt = (i >= r_pre);
            rr = (i == r_pre + rr_stall) ? 1'b1 : (bt ? 1'b0 : 1'($urandom % 2));
            rd = bt ? data : $urandom;
            rs = bt ? resp : 2'($urandom);
            m_if.rvalid = bt;
            m_if.rdata  = rd;
            m_if.rresp  = rs;
            if (win == 0) begin
                s0_if.rready = rr; s1_if.rready = 1'($urandom % 2);
            end else begin
                s1_if.rready = rr; s0_if.rready = 1'($urandom % 2);
            end
            @(negedge aclk);
            chk("data_grant", grant, eg);
            chk("data_m_arvalid", m_if.arvalid, 1'b0);
            chk("data_m_rready", m_if.rready, rr);
            chk("data_arready0", s0_if.arready, 1'b0);
            chk("data_arready1", s1_if.arready, 1'b0);
            chk("data_w_rvalid", (win == 0) ? s0_if.rvalid : s1_if.rvalid, bt);
            chk("data_w_rdata",  (win == 0) ? s0_if.rdata  : s1_if.rdata,  rd);
            chk("data_w_rresp",  (win == 0) ? s0_if.rresp  : s1_if.rresp,  rs);
            chk("data_l_rvalid", (win == 0) ? s1_if.rvalid : s0_if.rvalid, 1'b0);
            chk("data_l_rdata",  (win == 0) ? s1_if.rdata  : s0_if.rdata,  32'h0);
            chk("data_l_rresp",  (win == 0) ? s1_if.rresp  : s0_if.rresp,  2'b00);
            @(posedge aclk); #1;
        end
        m_if.rvalid  = 1'b0;
        s0_if.rready = 1'b0;
        s1_if.rready = 1'b0;
        chk("end_grant", grant, 2'b00);
    endtask

    initial begin
        areset        = 1'b1;
        s0_if.arvalid = 1'b0; s0_if.araddr = 32'h0; s0_if.arprot = 3'd0; s0_if.rready = 1'b0;
        s1_if.arvalid = 1'b1; s1_if.araddr = 32'h0; s1_if.arprot = 3'd0; s1_if.rready = 1'b1;
        m_if.arready  = 1'b0; m_if.rvalid  = 1'b1; m_if.rdata = 32'hFFFF_FFFF; m_if.rresp = 2'b11;

        // reset state, with a request and a downstream beat present
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_m_arvalid", m_if.arvalid, 1'b0);
        chk("rst_m_araddr", m_if.araddr, 32'h0);
        chk("rst_m_arprot", m_if.arprot, 3'd0);
        chk("rst_arready1", s1_if.arready, 1'b0);
        chk("rst_rvalid1", s1_if.rvalid, 1'b0);
        chk("rst_rdata1", s1_if.rdata, 32'h0);
        chk("rst_rresp1", s1_if.rresp, 2'b00);
        chk("rst_m_rready", m_if.rready, 1'b0);
        areset = 1'b0; s1_if.arvalid = 1'b0; s1_if.rready = 1'b0;
        m_if.rvalid = 1'b0; m_if.rresp = 2'b00;
        @(posedge aclk); #1;

        // port 0 alone, single-cycle address acceptance
        req(0, 32'h0000_1000, 3'd0);
        do_txn(0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0);

        // both held: eight port-0 grants then port 1, twice (counter cleared)
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 0; k <= LIMIT; k++) begin
                req(0, 32'h0000_2000, 3'd1);
                req(1, 32'h0000_3000, 3'd2);
                do_txn((k == LIMIT) ? 1 : 0, 0, 0, 0, $urandom, 2'b00, 1'b0);
            end
        end
        s0_if.arvalid = 1'b0;

        // delayed arready; port 1 request raised mid-transaction must wait
        req(0, 32'h0000_5000, 3'd5);
        do_txn(0, 4, 1, 0, $urandom, 2'b00, 1'b1);
        do_txn(1, 0, 0, 0, $urandom, 2'b00, 1'b0);

        // rready back-pressure for three cycles
        req(0, 32'h0000_6000, 3'd0);
        do_txn(0, 0, 0, 3, 32'hA5A5_5A5A, 2'b00, 1'b0);

        // error response passes through and leaves arbitration alone
        req(1, 32'h0000_7000, 3'd7);
        do_txn(1, 1, 1, 1, $urandom, 2'b10, 1'b0);
        req(0, 32'h0000_7100, 3'd0);
        req(1, 32'h0000_7200, 3'd0);
        do_txn(0, 0, 0, 0, $urandom, 2'b11, 1'b0);
        do_txn(1, 0, 0, 0, $urandom, 2'b00, 1'b0);

        // reset in the middle of DATA
        req(0, 32'h0000_8000, 3'd1);
        @(negedge aclk);
        chk("r30_arready0", s0_if.arready, 1'b1);
        @(posedge aclk); #1;
        s0_if.arvalid = 1'b0; m_if.arready = 1'b1;
        @(posedge aclk); #1;
        m_if.arready = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 32'h1234_5678;
        s0_if.rready = 1'b0; s1_if.arvalid = 1'b1;
        @(negedge aclk);
        chk("r30_pre_rvalid0", s0_if.rvalid, 1'b1);
        chk("r30_pre_grant", grant, 2'b01);
        #2 areset = 1'b1;
        #1;
        chk("r30_grant", grant, 2'b00);
        chk("r30_m_arvalid", m_if.arvalid, 1'b0);
        chk("r30_m_araddr", m_if.araddr, 32'h0);
        chk("r30_rvalid0", s0_if.rvalid, 1'b0);
        chk("r30_rdata0", s0_if.rdata, 32'h0);
        chk("r30_arready1", s1_if.arready, 1'b0);
        starve_m = 0;
        @(posedge aclk); #1;
        s1_if.arvalid = 1'b0; s0_if.rready = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("r30_spur_rvalid0", s0_if.rvalid, 1'b0);
        chk("r30_spur_rvalid1", s1_if.rvalid, 1'b0);
        chk("r30_spur_m_rready", m_if.rready, 1'b0);
        chk("r30_spur_grant", grant, 2'b00);
        @(posedge aclk); #1;
        m_if.rvalid = 1'b0; s0_if.rready = 1'b0;

        // randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            if (!s0_if.arvalid && ($urandom % 2 == 0)) req(0, $urandom, 3'($urandom));
            if (!s1_if.arvalid && ($urandom % 3 != 0)) req(1, $urandom, 3'($urandom));
            if (!s0_if.arvalid && !s1_if.arvalid) req(int'($urandom % 2), $urandom, 3'($urandom));
            do_txn(ref_winner(), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom, 2'($urandom), 1'b0);
        end

        s0_if.arvalid = 1'b0;
        s1_if.arvalid = 1'b0;
        repeat (2) @(posedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
